// File: rtl/datapath_pkg.sv
// Shared encodings for the self-sequencing datapath: ALU/shift/writeback
// select codes, the controller state encoding and status bit positions.
package datapath_pkg;

   // ALU operation codes
   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_AND  = 2'b10;
   localparam logic [1:0] ALU_NOTB = 2'b11;

   // B-operand shifter codes
   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL1 = 2'b01;
   localparam logic [1:0] SH_LSR1 = 2'b10;
   localparam logic [1:0] SH_ASR1 = 2'b11;

   // Writeback source select codes
   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_PC    = 2'b01;
   localparam logic [1:0] VSEL_IMM8  = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

   // Status register bit positions ({V,N,Z})
   localparam int STAT_Z = 0;
   localparam int STAT_N = 1;
   localparam int STAT_V = 2;

   // Controller states: one operation walks IDLE->RDA->RDB->EXEC->WB->IDLE
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RDA  = 3'd1,
      ST_RDB  = 3'd2,
      ST_EXEC = 3'd3,
      ST_WB   = 3'd4
   } state_e;

endpackage

// File: rtl/regfile_p.sv
// Parametrised register file: synchronous write, combinational read,
// asynchronous clear. With DATAPATH_SEQ_DBG_EN defined a second,
// read-only debug port is added.
module regfile_p #(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
`ifdef DATAPATH_SEQ_DBG_EN
   ,
   input  logic [AW-1:0]    dbg_addr_i,
   output logic [WIDTH-1:0] dbg_data_o
`endif
);

   logic [WIDTH-1:0] mem_q [NREGS];

   // Storage: cleared on reset, one write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

`ifdef DATAPATH_SEQ_DBG_EN
   assign dbg_data_o = mem_q[dbg_addr_i];
`endif

endmodule

// File: rtl/datapath_seq.sv
// Self-sequencing datapath. One decoded operation is accepted per
// op_valid/op_ready handshake and walked through read-A, read-B, execute
// and writeback; done pulses during writeback.
// Optional macro DATAPATH_SEQ_DBG_EN adds dbg_addr/dbg_data register peek.
module datapath_seq
   import datapath_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   parameter int PCW   = 9,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [AW-1:0]    op_rd,
   input  logic [AW-1:0]    op_rn,
   input  logic [AW-1:0]    op_rm,
   input  logic [1:0]       op_alu,
   input  logic [1:0]       op_shift,
   input  logic             op_asel,
   input  logic             op_bsel,
   input  logic [1:0]       op_vsel,
   input  logic             op_write,
   input  logic             op_loads,
   input  logic [WIDTH-1:0] sximm8,
   input  logic [WIDTH-1:0] sximm5,
   input  logic [PCW-1:0]   pc,
   input  logic [WIDTH-1:0] mdata,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       status
`ifdef DATAPATH_SEQ_DBG_EN
   ,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
`endif
);

   state_e state_q, state_d;

   // Captured operation
   logic [AW-1:0]    rd_q, rn_q, rm_q;
   logic [1:0]       alu_q, shift_q, vsel_q;
   logic             asel_q, bsel_q, write_q, loads_q;
   logic [WIDTH-1:0] sx8_q, sx5_q;
   logic [PCW-1:0]   pc_q;

   // Datapath registers
   logic [WIDTH-1:0] a_q, b_q, c_q;
   logic [2:0]       status_q;

   logic             accept_s;
   logic [AW-1:0]    raddr_s;
   logic [WIDTH-1:0] rdata_s;
   logic [WIDTH-1:0] shifted_s, ain_s, bin_s, alu_out_s;
   logic             ovf_s;
   logic [2:0]       status_d;
   logic             we_s;
   logic [WIDTH-1:0] wdata_s, pc_ext_s;

   assign op_ready = (state_q == ST_IDLE);
   assign done     = (state_q == ST_WB);
   assign accept_s = op_valid && op_ready;
   assign result   = c_q;
   assign status   = status_q;

   // Controller state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Controller next state: only the IDLE exit waits on a handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) state_d = ST_RDA;
            else          state_d = ST_IDLE;
         end
         ST_RDA:  state_d = ST_RDB;
         ST_RDB:  state_d = ST_EXEC;
         ST_EXEC: state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Operation register: loaded only on the IDLE handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q    <= '0;
         rn_q    <= '0;
         rm_q    <= '0;
         alu_q   <= 2'b00;
         shift_q <= 2'b00;
         vsel_q  <= 2'b00;
         asel_q  <= 1'b0;
         bsel_q  <= 1'b0;
         write_q <= 1'b0;
         loads_q <= 1'b0;
         sx8_q   <= '0;
         sx5_q   <= '0;
         pc_q    <= '0;
      end else if (accept_s) begin
         rd_q    <= op_rd;
         rn_q    <= op_rn;
         rm_q    <= op_rm;
         alu_q   <= op_alu;
         shift_q <= op_shift;
         vsel_q  <= op_vsel;
         asel_q  <= op_asel;
         bsel_q  <= op_bsel;
         write_q <= op_write;
         loads_q <= op_loads;
         sx8_q   <= sximm8;
         sx5_q   <= sximm5;
         pc_q    <= pc;
      end
   end

   // One shared read port: rm in RDB, rn otherwise
   assign raddr_s = (state_q == ST_RDB) ? rm_q : rn_q;

   regfile_p #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .we_i       (we_s),
      .waddr_i    (rd_q),
      .wdata_i    (wdata_s),
      .raddr_i    (raddr_s),
      .rdata_o    (rdata_s)
`ifdef DATAPATH_SEQ_DBG_EN
      ,
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data)
`endif
   );

   // Shifter, operand select and ALU with status flag generation
   always_comb begin
      shifted_s = b_q;
      case (shift_q)
         SH_NONE: shifted_s = b_q;
         SH_LSL1: shifted_s = {b_q[WIDTH-2:0], 1'b0};
         SH_LSR1: shifted_s = {1'b0, b_q[WIDTH-1:1]};
         SH_ASR1: shifted_s = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
         default: shifted_s = b_q;
      endcase

      if (asel_q) ain_s = '0;
      else        ain_s = a_q;
      if (bsel_q) bin_s = sx5_q;
      else        bin_s = shifted_s;

      alu_out_s = '0;
      ovf_s     = 1'b0;
      case (alu_q)
         ALU_ADD: begin
            alu_out_s = ain_s + bin_s;
            ovf_s     = (ain_s[WIDTH-1] == bin_s[WIDTH-1]) &&
                        (alu_out_s[WIDTH-1] != ain_s[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_out_s = ain_s - bin_s;
            ovf_s     = (ain_s[WIDTH-1] != bin_s[WIDTH-1]) &&
                        (alu_out_s[WIDTH-1] != ain_s[WIDTH-1]);
         end
         ALU_AND: begin
            alu_out_s = ain_s & bin_s;
            ovf_s     = 1'b0;
         end
         ALU_NOTB: begin
            alu_out_s = ~bin_s;
            ovf_s     = 1'b0;
         end
         default: begin
            alu_out_s = '0;
            ovf_s     = 1'b0;
         end
      endcase

      status_d         = 3'b000;
      status_d[STAT_Z] = (alu_out_s == '0);
      status_d[STAT_N] = alu_out_s[WIDTH-1];
      status_d[STAT_V] = ovf_s;
   end

   // Operand, result and status registers, each loaded in its own phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         status_q <= 3'b000;
      end else begin
         if (state_q == ST_RDA) a_q <= rdata_s;
         if (state_q == ST_RDB) b_q <= rdata_s;
         if (state_q == ST_EXEC) begin
            c_q <= alu_out_s;
            if (loads_q) status_q <= status_d;
         end
      end
   end

   // Writeback source select; mdata is taken live on the WB edge
   always_comb begin
      pc_ext_s          = '0;
      pc_ext_s[PCW-1:0] = pc_q;
      we_s              = (state_q == ST_WB) && write_q;
      case (vsel_q)
         VSEL_C:     wdata_s = c_q;
         VSEL_PC:    wdata_s = pc_ext_s;
         VSEL_IMM8:  wdata_s = sx8_q;
         VSEL_MDATA: wdata_s = mdata;
         default:    wdata_s = c_q;
      endcase
   end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised, self-sequencing successor to the single-cycle-controlled datapath.
- Accepts one decoded operation per valid/ready handshake. Runs it internally through read-A, read-B, execute and writeback phases, then pulses done.
- Register count, data width and PC width are generic. The controller FSM issues whole operations instead of per-cycle load strobes.
- Adds N/V status flags.

Parameters:
- WIDTH, 16: datapath/register width; must be ≥ 8.
- NREGS, 8: register-file entries; power of 2, ≥ 2. Address width AW = clog2(NREGS).
- PCW, 9: PC width; must be ≤ WIDTH. Zero-extended on writeback.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op_valid  in  1  operation offered
- op_ready  out  1  block can accept; high only in IDLE
- op_rd  in  AW  destination register
- op_rn  in  AW  A-operand register
- op_rm  in  AW  B-operand register
- op_alu  in  2  00 ADD, 01 SUB, 10 AND, 11 NOT B
- op_shift  in  2  00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
- op_asel  in  1  1: Ain = 0
- op_bsel  in  1  1: Bin = sximm5
- op_vsel  in  2  writeback source: 00 C, 01 PC, 10 sximm8, 11 mdata
- op_write  in  1  write R[rd] in WB
- op_loads  in  1  update status in EXEC
- sximm8  in  WIDTH  captured at accept
- sximm5  in  WIDTH  captured at accept
- pc  in  PCW  captured at accept
- mdata  in  WIDTH  sampled on the WB clock edge
- done  out  1  one-cycle pulse, high during WB
- result  out  WIDTH  C register
- status  out  3  {V,N,Z} register

Behaviour:
- Reset (async assert, rst_n low) puts the block in this state:
  - state = IDLE
  - all registers, A, B, C and result = 0
  - status = 3'b000, done = 0
  - op_ready = 1 while rst_n high and in IDLE
  - reset mid-operation aborts with no writeback and no done.
- FSM states: IDLE → RDA → RDB → EXEC → WB → IDLE.
  - Transitions are unconditional except the IDLE exit, which requires op_valid & op_ready.
- IDLE:
  - op_ready = 1.
  - On handshake, capture all op_* fields, sximm8, sximm5 and pc into the op register.
- RDA: A ← R[rn] at end of cycle.
- RDB: B ← R[rm] at end of cycle.
- EXEC:
  - Ain = asel ? 0 : A.
  - Bin = bsel ? sximm5 : shift(B).
  - C ← ALU(Ain, Bin).
  - If loads, status updates:
    - Z = (out == 0)
    - N = out[WIDTH-1]
    - V = signed overflow for ADD/SUB, 0 for AND/NOT.
  - Otherwise status holds.
- WB:
  - done = 1.
  - If write, R[rd] ← the vsel-selected value: C, {0, pc}, sximm8, or mdata sampled this edge.
  - result shows C, valid for the whole WB cycle and held until the next EXEC.
- Latency: handshake edge to done = 4 cycles. Throughput: 1 operation per 5 cycles; op_ready is low in RDA–WB.
- Arithmetic: modulo 2^WIDTH. LSL1/LSR1 shift in 0. ASR1 replicates the MSB.
- Hazards:
  - rd equal to rn or rm is legal; operands are read before WB.
  - The next operation reads the value written by the previous WB.
- op_* inputs are ignored outside the IDLE handshake.

Optional Feature:
- Macro: DATAPATH_SEQ_DBG_EN.
- Defined: adds input dbg_addr[AW] and output dbg_data[WIDTH].
  - dbg_data = R[dbg_addr], combinational.
  - Read-only, with no effect on the FSM.
- Undefined: neither port exists; no other behaviour changes.

Decomposition:
- Package datapath_pkg holds:
  - ALU op codes, shift codes and vsel codes as localparams
  - FSM state encoding, 3-bit
  - status bit indices Z = 0, N = 1, V = 2.
- One sub-module, regfile_p (parametrised WIDTH/NREGS):
  - synchronous write, combinational read
  - asynchronous active-low clear to 0.
- Shifter, ALU and FSM stay inline.

Test Plan:
- Reset mid-EXEC → done never pulses. Registers and status read 0. op_ready = 1 after rst_n rises.
- Write-immediate: op vsel=10, sximm8=16'h0005, rd=0, write=1 → done 4 cycles after handshake; dbg R0 = 5.
  - Then rd=1, sximm8=16'hFFF6 → R1 = 16'hFFF6.
- ADD with shift: rn=0 (5), rm=1 (16'hFFF6), shift=11, ADD, loads=1, vsel=00, rd=2.
  - ASR1 gives 16'hFFFB; result = 16'h0000, R2 = 0, status = 3'b001.
- Overflow: R0 = 16'h7FFF, R1 = 1, ADD, loads=1 → result 16'h8000, status = {V=1, N=1, Z=0} = 3'b110.
  - Repeat with loads=0 → status unchanged.
- Back-to-back with op_valid held high → op_ready low for 4 cycles; the second op is accepted exactly 1 cycle after done. PC write with pc=9'h1FF → R[rd] = 16'h01FF.
- mdata writeback with rd==rn: R3 = 16'h1234, op rn=3, rd=3, vsel=11, mdata=16'hBEEF presented only on the WB edge → R3 = 16'hBEEF. A held 16'h1234.
